// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core: FETCH/DECODE/EXEC/MEM/WB over a single shared req/ready memory port.
// Optional perf counters (perf_cycles, perf_retired) are built when MIPS_PERF_CNT_EN is defined.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DBG_REG  = 31
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic        retire,
  output logic        illegal,
  output logic [31:0] dbg_reg
`ifdef MIPS_PERF_CNT_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_retired
`endif
);

  localparam logic [4:0] DBG_IDX = DBG_REG[4:0];

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE   = 6'h05, OP_BLEZ  = 6'h06,
                         OP_BGTZ  = 6'h07, OP_ADDI  = 6'h08, OP_ADDIU = 6'h09,
                         OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI  = 6'h0C,
                         OP_ORI   = 6'h0D, OP_XORI  = 6'h0E, OP_LUI   = 6'h0F,
                         OP_LW    = 6'h23, OP_LBU   = 6'h24, OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03,
                         F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07,
                         F_JR   = 6'h08, F_ADD  = 6'h20, F_ADDU = 6'h21,
                         F_SUB  = 6'h22, F_SUBU = 6'h23, F_AND  = 6'h24,
                         F_OR   = 6'h25, F_XOR  = 6'h26, F_NOR  = 6'h27,
                         F_SLT  = 6'h2A, F_SLTU = 6'h2B;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

  state_t      state, state_nxt;
  logic [31:0] ir, a, b, alu_out, mdr;
  logic [31:0] rf [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] simm, zimm, br_tgt, j_tgt;

  assign op     = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign shamt  = ir[10:6];
  assign funct  = ir[5:0];
  assign simm   = {{16{ir[15]}}, ir[15:0]};
  assign zimm   = {16'h0000, ir[15:0]};
  // pc already points past the current instruction once we leave FETCH
  assign br_tgt = pc + {simm[29:0], 2'b00};
  assign j_tgt  = {pc[31:28], ir[25:0], 2'b00};

  logic [31:0] alu_res, ctl_tgt, lbu_val, wb_data;
  logic        legal, is_ctrl, is_load, is_store, take, link;
  logic [4:0]  dest;

  always_comb begin
    alu_res  = '0;
    legal    = 1'b1;
    is_ctrl  = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    take     = 1'b0;
    link     = 1'b0;
    ctl_tgt  = br_tgt;
    dest     = rt;
    case (op)
      OP_RTYPE: begin
        dest = rd;
        case (funct)
          F_SLL:         alu_res = b << shamt;
          F_SRL:         alu_res = b >> shamt;
          F_SRA:         alu_res = $signed(b) >>> shamt;
          F_SLLV:        alu_res = b << a[4:0];
          F_SRLV:        alu_res = b >> a[4:0];
          F_SRAV:        alu_res = $signed(b) >>> a[4:0];
          F_JR: begin
            is_ctrl = 1'b1;
            take    = 1'b1;
            ctl_tgt = a;
          end
          F_ADD, F_ADDU: alu_res = a + b;
          F_SUB, F_SUBU: alu_res = a - b;
          F_AND:         alu_res = a & b;
          F_OR:          alu_res = a | b;
          F_XOR:         alu_res = a ^ b;
          F_NOR:         alu_res = ~(a | b);
          F_SLT:         alu_res = {31'd0, $signed(a) < $signed(b)};
          F_SLTU:        alu_res = {31'd0, a < b};
          default:       legal = 1'b0;
        endcase
      end
      OP_J, OP_JAL: begin
        is_ctrl = 1'b1;
        take    = 1'b1;
        link    = (op == OP_JAL);
        ctl_tgt = j_tgt;
      end
      OP_BEQ:  begin is_ctrl = 1'b1; take = (a == b); end
      OP_BNE:  begin is_ctrl = 1'b1; take = (a != b); end
      OP_BLEZ: begin is_ctrl = 1'b1; take = ($signed(a) <= 32'sd0); end
      OP_BGTZ: begin is_ctrl = 1'b1; take = ($signed(a) >  32'sd0); end
      OP_ADDI, OP_ADDIU: alu_res = a + simm;
      OP_SLTI:  alu_res = {31'd0, $signed(a) < $signed(simm)};
      OP_SLTIU: alu_res = {31'd0, a < simm};
      OP_ANDI:  alu_res = a & zimm;
      OP_ORI:   alu_res = a | zimm;
      OP_XORI:  alu_res = a ^ zimm;
      OP_LUI:   alu_res = {ir[15:0], 16'h0000};
      OP_LW, OP_LBU: begin
        is_load = 1'b1;
        alu_res = a + simm;
      end
      OP_SW: begin
        is_store = 1'b1;
        alu_res  = a + simm;
      end
      default: legal = 1'b0;
    endcase
  end

  // big-endian byte lanes: address offset 0 is the most significant byte
  always_comb begin
    case (alu_out[1:0])
      2'd0:    lbu_val = {24'h0, mdr[31:24]};
      2'd1:    lbu_val = {24'h0, mdr[23:16]};
      2'd2:    lbu_val = {24'h0, mdr[15:8]};
      default: lbu_val = {24'h0, mdr[7:0]};
    endcase
  end

  assign wb_data = (op == OP_LW) ? mdr : (op == OP_LBU) ? lbu_val : alu_out;

  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc;
    retire    = 1'b0;
    rf_we     = 1'b0;
    rf_wa     = dest;
    rf_wd     = wb_data;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        if (!legal) begin
          state_nxt = S_WB;
        end else if (is_ctrl) begin
          retire    = 1'b1;
          rf_we     = link;
          rf_wa     = 5'd31;
          rf_wd     = pc;
          state_nxt = S_FETCH;
        end else if (is_load || is_store) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = is_store;
        mem_addr = {alu_out[31:2], 2'b00};
        if (mem_ready) begin
          retire    = is_store;
          state_nxt = is_store ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        retire    = 1'b1;
        rf_we     = legal;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
    // reset abandons any bus cycle at once, not at the next edge
    if (!rst) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      retire  = 1'b0;
      rf_we   = 1'b0;
    end
  end

  assign mem_wdata = b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_FETCH: if (mem_ready) begin
          ir <= mem_rdata;
          pc <= pc + 32'd4;
        end
        S_DECODE: begin
          a <= rf[rs];
          b <= rf[rt];
        end
        S_EXEC: begin
          alu_out <= alu_res;
          if (!legal) illegal <= 1'b1;
          else if (is_ctrl && take) pc <= ctl_tgt;
        end
        S_MEM: if (mem_ready) mdr <= mem_rdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (rf_we && rf_wa != 5'd0) begin
      rf[rf_wa] <= rf_wd;
    end
  end

  assign dbg_reg = rf[DBG_IDX];

`ifdef MIPS_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cycles  <= '0;
      perf_retired <= '0;
    end else begin
      perf_cycles <= perf_cycles + 32'd1;
      if (retire) perf_retired <= perf_retired + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: directed program, mid-transaction reset, then a random
// program, all checked against an instruction-level reference model and a wait-state memory.
module tb_mips_multicycle_core;
  logic        clk = 1'b0, rst = 1'b0, mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_req, mem_we, retire, illegal;
  logic [31:0] mem_addr, mem_wdata, pc, dbg_reg;
`ifdef MIPS_PERF_CNT_EN
  logic [31:0] perf_cycles, perf_retired;
`endif

  mips_multicycle_core #(.RESET_PC(32'h0), .DBG_REG(31)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
    .retire(retire), .illegal(illegal), .dbg_reg(dbg_reg)
`ifdef MIPS_PERF_CNT_EN
    , .perf_cycles(perf_cycles), .perf_retired(perf_retired)
`endif
  );

  always #5 clk = ~clk;

  int          nchk = 0, npass = 0;
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  logic [31:0] ref_rf [32];
  logic [31:0] ref_pc;
  logic        ref_ill;
  int          lat, waits_seen, max_wait, wait_left, nret;
  bit          force_stall, req_active, ret_seen;
  logic [31:0] cap_addr, cap_wdata;
  logic        cap_we;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  task automatic put(input logic [31:0] addr, input logic [31:0] w);
    mem[addr[11:2]] = w;
    ref_mem[addr[11:2]] = w;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) ref_rf[r] = v;
  endtask

  // One whole instruction at a time; base = zero-wait cycle count of that instruction class.
  task automatic iss_step(output int base);
    logic [31:0] ins, a, b, simm, zimm, npc, ea, w;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh;
    ins = ref_mem[ref_pc[11:2]];
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; sh = ins[10:6];
    fn = ins[5:0];
    a = ref_rf[rs]; b = ref_rf[rt];
    simm = {{16{ins[15]}}, ins[15:0]};
    zimm = {16'h0, ins[15:0]};
    ea = a + simm;
    npc = ref_pc + 4;
    base = 4;
    case (op)
      6'h00: case (fn)
        6'h00: wr(rd, b << sh);
        6'h02: wr(rd, b >> sh);
        6'h03: wr(rd, $signed(b) >>> sh);
        6'h04: wr(rd, b << a[4:0]);
        6'h06: wr(rd, b >> a[4:0]);
        6'h07: wr(rd, $signed(b) >>> a[4:0]);
        6'h08: begin npc = a; base = 3; end
        6'h20, 6'h21: wr(rd, a + b);
        6'h22, 6'h23: wr(rd, a - b);
        6'h24: wr(rd, a & b);
        6'h25: wr(rd, a | b);
        6'h26: wr(rd, a ^ b);
        6'h27: wr(rd, ~(a | b));
        6'h2A: wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
        6'h2B: wr(rd, (a < b) ? 32'd1 : 32'd0);
        default: ref_ill = 1'b1;
      endcase
      6'h02: begin npc = {npc[31:28], ins[25:0], 2'b00}; base = 3; end
      6'h03: begin wr(5'd31, ref_pc + 4); npc = {npc[31:28], ins[25:0], 2'b00}; base = 3; end
      6'h04: begin if (a == b) npc = npc + (simm << 2); base = 3; end
      6'h05: begin if (a != b) npc = npc + (simm << 2); base = 3; end
      6'h06: begin if ($signed(a) <= 0) npc = npc + (simm << 2); base = 3; end
      6'h07: begin if ($signed(a) > 0) npc = npc + (simm << 2); base = 3; end
      6'h08, 6'h09: wr(rt, a + simm);
      6'h0A: wr(rt, ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0);
      6'h0B: wr(rt, (a < simm) ? 32'd1 : 32'd0);
      6'h0C: wr(rt, a & zimm);
      6'h0D: wr(rt, a | zimm);
      6'h0E: wr(rt, a ^ zimm);
      6'h0F: wr(rt, {ins[15:0], 16'h0});
      6'h23: begin wr(rt, ref_mem[ea[11:2]]); base = 5; end
      6'h24: begin
        w = ref_mem[ea[11:2]];
        wr(rt, (w >> (8 * (3 - ea[1:0]))) & 32'hFF);
        base = 5;
      end
      6'h2B: ref_mem[ea[11:2]] = b;
      default: ref_ill = 1'b1;
    endcase
    ref_pc = npc;
  endtask

  task automatic retire_check();
    int base;
    iss_step(base);
    nret++;
    check("latency", lat, base + waits_seen);
    lat = 0;
    waits_seen = 0;
    check("pc", pc, ref_pc);
    check("dbg_reg", dbg_reg, ref_rf[31]);
    check("illegal", {31'd0, illegal}, {31'd0, ref_ill});
`ifdef MIPS_PERF_CNT_EN
    check("perf_retired", perf_retired, nret);
`endif
  endtask

  // One clock: memory responds at the falling edge, retire is evaluated after the rising edge.
  task automatic tick();
    @(negedge clk);
    lat++;
    if (mem_req) begin
      if (req_active) begin
        check("addr_stable", mem_addr, cap_addr);
        check("wdata_stable", mem_wdata, cap_wdata);
        check("we_stable", {31'd0, mem_we}, {31'd0, cap_we});
      end else begin
        req_active = 1'b1;
        cap_addr = mem_addr; cap_wdata = mem_wdata; cap_we = mem_we;
        check("addr_align", {30'd0, mem_addr[1:0]}, 32'd0);
        wait_left = force_stall ? 1000 : $urandom_range(0, max_wait);
      end
      if (wait_left > 0) begin
        wait_left--;
        waits_seen++;
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end else begin
        mem_ready = 1'b1;
        req_active = 1'b0;
        if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
        else        mem_rdata = mem[mem_addr[11:2]];
      end
    end else begin
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
    end
    #1;
    ret_seen = retire;
    @(posedge clk);
    #1;
    if (ret_seen) retire_check();
  endtask

  task automatic reset_assert();
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_retire", {31'd0, retire}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_dbg_reg", dbg_reg, 32'h0);
    for (int i = 0; i < 32; i++) ref_rf[i] = '0;
    ref_pc = 32'h0; ref_ill = 1'b0;
    nret = 0; lat = 0; waits_seen = 0; wait_left = 0;
    req_active = 1'b0; force_stall = 1'b0;
  endtask

  task automatic reset_release();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("first_req", {31'd0, mem_req}, 32'd1);
    check("first_addr", mem_addr, 32'h0);
  endtask

  task automatic run_to(input logic [31:0] end_pc, input int budget);
    int cyc = 0;
    while (ref_pc != end_pc && cyc < budget) begin
      tick();
      cyc++;
    end
    check("reached_end", ref_pc, end_pc);
  endtask

  function automatic logic [4:0] pick();
    case ($urandom_range(0, 6))
      0: return 5'd0;  1: return 5'd1;  2: return 5'd2;  3: return 5'd3;
      4: return 5'd4;  5: return 5'd5;  default: return 5'd31;
    endcase
  endfunction

  function automatic logic [5:0] alu_fn(input int k);
    case (k)
      0: return 6'h20;  1: return 6'h21;  2: return 6'h22;  3: return 6'h23;
      4: return 6'h24;  5: return 6'h25;  6: return 6'h26;  7: return 6'h27;
      8: return 6'h2A;  9: return 6'h2B;  10: return 6'h04; 11: return 6'h06;
      default: return 6'h07;
    endcase
  endfunction

  localparam int NBODY = 80;
  localparam int NPROG = NBODY + 6;

  task automatic gen_random();
    logic [31:0] ins;
    logic [4:0]  regs [6];
    regs[0] = 5'd1; regs[1] = 5'd2; regs[2] = 5'd3; regs[3] = 5'd4; regs[4] = 5'd5;
    regs[5] = 5'd31;
    for (int i = 0; i < 1024; i++) begin
      ins = (i < 512) ? 32'h0 : $urandom;
      mem[i] = ins;
      ref_mem[i] = ins;
    end
    for (int k = 0; k < 4; k++) begin
      put(8 * k,     enc_i(6'h0F, 5'd0, 5'(k + 1), 16'($urandom)));
      put(8 * k + 4, enc_i(6'h0D, 5'(k + 1), 5'(k + 1), 16'($urandom)));
    end
    for (int i = 8; i < NBODY; i++) begin
      case ($urandom_range(0, 12))
        1:  ins = enc_r(pick(), pick(), pick(), 5'($urandom), 6'($urandom_range(0, 1) * 2 +
                        $urandom_range(0, 1)) | 6'h00);
        2:  ins = enc_i(6'($urandom_range(8, 15)), pick(), pick(), 16'($urandom));
        3:  ins = enc_i(6'h2B, 5'd0, pick(), 16'(32'h800 + 4 * $urandom_range(0, 511)));
        4:  ins = enc_i(6'h23, 5'd0, pick(), 16'(32'h800 + 4 * $urandom_range(0, 511)));
        5:  ins = enc_i(6'h24, 5'd0, pick(), 16'(32'h800 + $urandom_range(0, 2047)));
        6:  ins = enc_i(6'($urandom_range(4, 7)), pick(), pick(), 16'($urandom_range(0, 2)));
        7:  ins = enc_j(6'h02, 26'(i + 1 + $urandom_range(0, 2)));
        8:  ins = enc_j(6'h03, 26'(i + 1 + $urandom_range(0, 2)));
        9:  ins = ($urandom_range(0, 1) != 0) ? {6'h3F, 26'($urandom)}
                                               : enc_r(pick(), pick(), pick(), 5'd0, 6'h01);
        default: ins = enc_r(pick(), pick(), pick(), 5'd0, alu_fn($urandom_range(0, 12)));
      endcase
      put(32'(4 * i), ins);
    end
    for (int j = 0; j < 6; j++)
      put(32'(4 * (NBODY + j)), enc_i(6'h2B, 5'd0, regs[j], 16'(32'h800 + 4 * j)));
  endtask

  initial begin
    max_wait = 0;
    // directed program, zero-wait memory
    reset_assert();
    for (int i = 0; i < 1024; i++) put(32'(4 * i), 32'h0);
    put(32'h00, enc_i(6'h0D, 5'd0, 5'd1, 16'h00FF));
    put(32'h04, enc_i(6'h0F, 5'd0, 5'd2, 16'h8000));
    put(32'h08, enc_r(5'd2, 5'd1, 5'd3, 5'd0, 6'h2A));
    put(32'h0C, enc_r(5'd2, 5'd1, 5'd4, 5'd0, 6'h2B));
    put(32'h10, enc_i(6'h04, 5'd0, 5'd0, 16'd2));
    put(32'h14, enc_i(6'h0D, 5'd0, 5'd7, 16'd1));
    put(32'h18, enc_i(6'h0D, 5'd0, 5'd7, 16'd2));
    put(32'h1C, enc_i(6'h2B, 5'd0, 5'd1, 16'h0808));
    put(32'h20, enc_j(6'h03, 26'h40));
    put(32'h24, enc_i(6'h2B, 5'd0, 5'd3, 16'h0810));
    put(32'h28, enc_i(6'h2B, 5'd0, 5'd4, 16'h0814));
    put(32'h2C, enc_i(6'h2B, 5'd0, 5'd5, 16'h0818));
    put(32'h30, enc_i(6'h2B, 5'd0, 5'd6, 16'h081C));
    put(32'h34, enc_r(5'd1, 5'd1, 5'd0, 5'd0, 6'h21));
    put(32'h38, enc_i(6'h2B, 5'd0, 5'd0, 16'h0820));
    put(32'h3C, enc_i(6'h2B, 5'd0, 5'd7, 16'h0824));
    put(32'h40, 32'hFC00_0000);
    put(32'h44, enc_i(6'h0D, 5'd0, 5'd31, 16'h0055));
    put(32'h100, enc_i(6'h23, 5'd0, 5'd5, 16'h0808));
    put(32'h104, enc_i(6'h24, 5'd0, 5'd6, 16'h080D));
    put(32'h108, enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08));
    put(32'h80C, 32'h1122_3344);
    reset_release();
    run_to(32'h48, 2000);
    check("sw_r1", mem[32'h808 >> 2], 32'h0000_00FF);
    check("slt_r3", mem[32'h810 >> 2], 32'd1);
    check("sltu_r4", mem[32'h814 >> 2], 32'd0);
    check("lw_r5", mem[32'h818 >> 2], 32'h0000_00FF);
    check("lbu_r6", mem[32'h81C >> 2], 32'h0000_0022);
    check("r0_zero", mem[32'h820 >> 2], 32'd0);
    check("branch_skip_r7", mem[32'h824 >> 2], 32'd0);
    check("illegal_sticky", {31'd0, illegal}, 32'd1);
    check("final_r31", dbg_reg, 32'h55);

    // stall a fetch forever, then reset in the middle of it
    force_stall = 1'b1;
    repeat (6) tick();
    check("stalled_req", {31'd0, mem_req}, 32'd1);
    #2;
    reset_assert();

    // random program with random wait states
    max_wait = 3;
    gen_random();
    reset_release();
    run_to(32'(4 * NPROG), 20000);
    for (int i = 512; i < 1024; i++) check("data_mem", mem[i], ref_mem[i]);
`ifdef MIPS_PERF_CNT_EN
    check("perf_cycles_min", {31'd0, perf_cycles >= 32'(4 * nret)}, 32'd1);
`endif
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
- Multi-cycle successor to the team's single-cycle MIPS CPU; executes one instruction per 3–5+ cycles through an explicit FSM.
- Uses a single shared memory port for both instruction and data, with a req/ready handshake, so it can sit directly on slow on-chip RAM or a bus bridge.
- Adds parametrised reset vector, a selectable debug register tap, a full register-file reset, and correct signed/unsigned compares and shifts.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DBG_REG, 31, register index driven onto dbg_reg (0–31).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- mem_req  output  1  memory request; held until accepted.
- mem_we  output  1  1 = write (SW), 0 = read.
- mem_addr  output  32  word address; bits [1:0] always 00.
- mem_wdata  output  32  store data (rt value).
- mem_rdata  input  32  read data; valid in the cycle mem_ready=1.
- mem_ready  input  1  transaction completes on an edge where mem_req & mem_ready.
- pc  output  32  address of the next instruction to fetch.
- retire  output  1  one-cycle pulse per completed instruction.
- illegal  output  1  sticky flag; set by any unsupported opcode/funct.
- dbg_reg  output  32  current value of register DBG_REG.

Behaviour:
- Reset (async, rst=0):
  - state = FETCH; pc = RESET_PC; all 32 registers = 0.
  - mem_req = 0, mem_we = 0, retire = 0, illegal = 0.
  - Any in-flight transaction is abandoned immediately.
- FETCH:
  - Drives mem_req=1, mem_we=0, mem_addr=pc.
  - On ready: IR <= mem_rdata; pc <= pc+4; go to DECODE.
- DECODE:
  - A <= rf[rs]; B <= rf[rt]; go to EXEC.
- EXEC: ALU result latched.
  - Branches and jumps: pc updated if taken; retire; go to FETCH.
  - LW, LBU, SW: go to MEM.
  - All others: go to WB.
- MEM:
  - mem_req=1; mem_addr={ALU[31:2],2'b00}; mem_we=1 for SW.
  - On ready: loads go to WB with MDR <= mem_rdata.
  - On ready: SW retires and goes to FETCH.
- WB: rf[dest] <= result; retire; go to FETCH.
- Latency with zero-wait memory:
  - ALU/immediate: 4 cycles. LW/LBU: 5. SW: 4. Branch/jump: 3.
  - Each wait cycle (mem_req=1, mem_ready=0) adds one cycle.
- Handshake: mem_addr, mem_we and mem_wdata are stable while mem_req=1; mem_req drops the cycle after acceptance.
- mem_ready while mem_req=0 is ignored.
- Supported instructions:
  - R-type: ADDU, ADD, SUBU, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, SLLV, SRLV, SRAV, JR.
  - I-type: ADDI, ADDIU, ANDI, ORI, XORI, LUI, SLTI, SLTIU, LW, LBU, SW, BEQ, BNE, BLEZ, BGTZ.
  - J-type: J, JAL.
  - ADD/ADDI wrap modulo 2^32; no overflow trap.
- Arithmetic rules:
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned.
  - SLTIU, ADDI, ADDIU and memory offsets use a sign-extended immediate.
  - ANDI/ORI/XORI use a zero-extended immediate.
  - Variable shifts use rs[4:0] only.
  - SRA/SRAV are arithmetic shifts.
- Branch and jump targets (no delay slot):
  - Branch target = pc(already +4) + (sext(imm)<<2).
  - J/JAL target = {pc[31:28], imm26, 2'b00}.
  - JAL writes pc(+4) to r31.
  - JR target = A.
- LBU is big-endian: addr[1:0]=0 selects rdata[31:24], 1 → [23:16], 2 → [15:8], 3 → [7:0]; result is zero-extended.
- Register 0: writes to r0 are discarded; it always reads 0.
- Illegal instruction: sets illegal (sticky until reset), executes as a NOP, retires, pc advances by 4.

Optional Feature:
- Macro: MIPS_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_cycles[31:0] (increments every cycle out of reset) and perf_retired[31:0] (increments on retire).
  - Both counters wrap at 2^32 and clear on reset.
- When undefined: the ports are absent; no counter logic.

Test Plan:
- Reset/fetch: release rst, zero-wait memory → mem_req=1 with mem_addr=RESET_PC on the first cycle; pc=4 after fetch.
- ALU: ORI r1,r0,0x00FF; LUI r2,0x8000; SLT r3,r2,r1; SLTU r4,r2,r1 → r1=0x000000FF, r3=1, r4=0; retire every 4 cycles.
- Memory with waits:
  - Mem returns ready after 3 waits; SW r1,8(r0) then LW r5,8(r0) → r5=0x000000FF, with mem_addr/mem_wdata stable during the waits.
  - LBU r6,9(r0) with word 0x11223344 → r6=0x22.
- Control flow:
  - BEQ r0,r0,+2 at 0x10 → next fetch at 0x1C.
  - JAL 0x40 at 0x20 → r31=0x24 and fetch at 0x100.
  - JR r31 → fetch at 0x24.
- Boundary: ADDU r0,r1,r1 → r0 stays 0; opcode 0x3F → illegal=1, pc+4, retire pulses; assert rst while mem_req=1 and mem_ready=0 → mem_req=0 immediately, pc=RESET_PC.
- With MIPS_PERF_CNT_EN: 10 ALU instructions, zero-wait → perf_retired=10, perf_cycles≥40.
